// File: rtl/jtkunio_dwnld.sv
// ROM download front end for the Kunio core: maps ioctl bytes to SDRAM bank/word writes
// through a two-entry queue. Define JTKUNIO_GFXSWAP_EN to interleave gfx plane halves (ba2/ba3).
module jtkunio_dwnld #(
  parameter logic [24:0] BA1_START = 25'h1_0000,
  parameter logic [24:0] BA2_START = 25'h3_0000,
  parameter logic [24:0] BA3_START = 25'h5_8000,
  parameter logic [24:0] END_ADDR  = 25'h9_8000
) (
  input  logic        rst_n,
  input  logic        clk,
  input  logic        downloading,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        ioctl_wr,
  output logic [21:0] prog_addr,
  output logic [15:0] prog_data,
  output logic [1:0]  prog_mask,
  output logic [1:0]  prog_ba,
  output logic        prog_we,
  input  logic        prog_rdy,
  output logic        dwnld_busy,
  output logic        ovf
);

  typedef enum logic { IDLE, WAIT } state_t;

  typedef struct packed {
    logic [21:0] addr;
    logic [1:0]  ba;
    logic [1:0]  mask;
    logic [7:0]  dout;
  } entry_t;

  state_t      state;
  entry_t      q0, q1;
  logic        v0, v1;
  logic        dec_ok;
  logic [1:0]  dec_ba;
  logic [22:0] dec_off;
  logic [22:0] swz_off;
  entry_t      dec_entry;
  logic        push, pop;
  logic        eff0, eff1;

  // Only the low 23 offset bits matter (banks up to 8 MB), so the subtraction is done at that width.
  always_comb begin
    dec_ok  = 1'b1;
    dec_ba  = 2'd0;
    dec_off = ioctl_addr[22:0];
    if (ioctl_addr < BA1_START) begin
      dec_ba  = 2'd0;
      dec_off = ioctl_addr[22:0];
    end else if (ioctl_addr < BA2_START) begin
      dec_ba  = 2'd1;
      dec_off = ioctl_addr[22:0] - BA1_START[22:0];
    end else if (ioctl_addr < BA3_START) begin
      dec_ba  = 2'd2;
      dec_off = ioctl_addr[22:0] - BA2_START[22:0];
    end else if (ioctl_addr < END_ADDR) begin
      dec_ba  = 2'd3;
      dec_off = ioctl_addr[22:0] - BA3_START[22:0];
    end else begin
      dec_ok  = 1'b0;
    end
    swz_off = dec_off;
`ifdef JTKUNIO_GFXSWAP_EN
    if (dec_ba[1])
      swz_off = {dec_off[22:6], dec_off[4:1], dec_off[5], dec_off[0]};
`endif
    dec_entry.addr = swz_off[22:1];
    dec_entry.ba   = dec_ba;
    dec_entry.mask = swz_off[0] ? 2'b01 : 2'b10;
    dec_entry.dout = ioctl_dout;
  end

  assign push = ioctl_wr & downloading & dec_ok;
  assign pop  = (state == WAIT) & prog_we & prog_rdy;

  // Occupancy as seen after this cycle's pop, so a simultaneous pop makes room for the push.
  assign eff0 = pop ? v1 : v0;
  assign eff1 = pop ? 1'b0 : v1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q0  <= '0;
      q1  <= '0;
      v0  <= 1'b0;
      v1  <= 1'b0;
      ovf <= 1'b0;
    end else begin
      if (pop) begin
        q0 <= q1;
        v0 <= v1;
        v1 <= 1'b0;
      end
      if (push) begin
        if (!eff0) begin
          q0 <= dec_entry;
          v0 <= 1'b1;
        end else if (!eff1) begin
          q1 <= dec_entry;
          v1 <= 1'b1;
        end else begin
          ovf <= 1'b1;
        end
      end
    end
  end

  // Head entry stays in the queue until accepted; returning to IDLE forces a low prog_we cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      prog_we   <= 1'b0;
      prog_addr <= '0;
      prog_data <= '0;
      prog_mask <= 2'b11;
      prog_ba   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (v0) begin
            prog_addr <= q0.addr;
            prog_data <= {q0.dout, q0.dout};
            prog_mask <= q0.mask;
            prog_ba   <= q0.ba;
            prog_we   <= 1'b1;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (prog_rdy) begin
            prog_we <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      dwnld_busy <= 1'b0;
    else
      dwnld_busy <= downloading | v0 | v1 | prog_we;
  end

endmodule
